xgpon_burst_rx_delineator: RTL and testbench



---
 rtl/xgpon_burst_rx_delineator.sv | 226 ++++++++++++++++++++++
 tb/tb_xgpon_burst_rx_delineator.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xgpon_burst_rx_delineator.sv
// XG-PON upstream burst receiver: error-tolerant delimiter hunt, bit-alignment lock,
// header decode and aligned payload streaming. Define XGPON_RX_STATS_EN for the statistics counters.
module xgpon_burst_rx_delineator #(
    parameter logic [31:0] DELIMITER     = 32'hB2C5_0FA1,
    parameter int          DELIM_MAX_ERR = 2,
    parameter int          MAX_LEN       = 2048,
    parameter int          GAP_TIMEOUT   = 16
) (
    input  logic        rx_core_clk,
    input  logic        rx_core_reset_n,
    input  logic [31:0] rx_data,
    input  logic        rx_data_valid,
    output logic [31:0] m_data,
    output logic        m_valid,
    output logic        m_last,
    output logic [15:0] m_onu_id,
    output logic        burst_active,
    output logic [4:0]  bit_offset,
    output logic        err_hdr,
    output logic        err_trunc,
    output logic [15:0] burst_ok_cnt,
    output logic [15:0] hdr_err_cnt,
    output logic [15:0] trunc_cnt
);

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_HEADER  = 2'd1,
        ST_PAYLOAD = 2'd2
    } state_t;

    function automatic logic [5:0] popcount32(input logic [31:0] v);
        logic [5:0] n;
        n = 6'd0;
        for (int i = 0; i < 32; i++) begin
            n = n + {5'd0, v[i]};
        end
        return n;
    endfunction

    state_t      state_q, state_d;
    logic [31:0] prev_q, prev_d;
    logic [4:0]  bit_offset_q, bit_offset_d;
    logic [15:0] len_q, len_d;
    logic [15:0] word_cnt_q, word_cnt_d;
    logic [15:0] gap_cnt_q, gap_cnt_d;
    logic [31:0] m_data_q, m_data_d;
    logic        m_valid_q, m_valid_d;
    logic        m_last_q, m_last_d;
    logic [15:0] m_onu_id_q, m_onu_id_d;
    logic        burst_active_q, burst_active_d;
    logic        err_hdr_q, err_hdr_d;
    logic        err_trunc_q, err_trunc_d;

    // The lowest window bit is never part of any candidate, so it is left out of the window.
    logic [62:0] win_s;
    logic [31:0] aligned_s;
    logic        hunt_hit_s;
    logic [4:0]  hunt_off_s;
    logic [15:0] gap_inc_s;

    assign win_s     = {prev_q, rx_data[31:1]};
    assign aligned_s = win_s[6'd62 - {1'b0, bit_offset_q} -: 32];
    assign gap_inc_s = gap_cnt_q + 16'd1;

    // Delimiter search over all 32 offsets; scanning downward lets the lowest offset win.
    always_comb begin
        logic match_v;
        hunt_hit_s = 1'b0;
        hunt_off_s = 5'd0;
        for (int k = 31; k >= 0; k--) begin
            match_v    = (popcount32(win_s[62 - k -: 32] ^ DELIMITER) <= 6'(DELIM_MAX_ERR));
            hunt_hit_s = hunt_hit_s | match_v;
            hunt_off_s = match_v ? 5'(k) : hunt_off_s;
        end
    end

    // Next-state and output computation for the hunt / header / payload sequencer.
    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        bit_offset_d = bit_offset_q;
        len_d        = len_q;
        word_cnt_d   = word_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        m_data_d     = m_data_q;
        m_valid_d    = 1'b0;
        m_last_d     = 1'b0;
        m_onu_id_d   = m_onu_id_q;
        err_hdr_d    = 1'b0;
        err_trunc_d  = 1'b0;
        if (rx_data_valid) begin
            prev_d = rx_data;
            case (state_q)
                ST_HUNT: begin
                    if (hunt_hit_s) begin
                        state_d      = ST_HEADER;
                        bit_offset_d = hunt_off_s;
                    end else begin
                        state_d = ST_HUNT;
                    end
                end
                ST_HEADER: begin
                    if ((aligned_s[31:16] == 16'd0) || (aligned_s[31:16] > 16'(MAX_LEN))) begin
                        err_hdr_d = 1'b1;
                        state_d   = ST_HUNT;
                    end else begin
                        len_d      = aligned_s[31:16];
                        m_onu_id_d = aligned_s[15:0];
                        word_cnt_d = 16'd0;
                        gap_cnt_d  = 16'd0;
                        state_d    = ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    gap_cnt_d = 16'd0;
                    m_data_d  = aligned_s;
                    m_valid_d = 1'b1;
                    if (word_cnt_q == (len_q - 16'd1)) begin
                        m_last_d = 1'b1;
                        state_d  = ST_HUNT;
                    end else begin
                        word_cnt_d = word_cnt_q + 16'd1;
                    end
                end
                default: begin
                    state_d = ST_HUNT;
                end
            endcase
        end else begin
            if (state_q == ST_PAYLOAD) begin
                if (gap_inc_s == 16'(GAP_TIMEOUT)) begin
                    err_trunc_d = 1'b1;
                    gap_cnt_d   = 16'd0;
                    state_d     = ST_HUNT;
                end else begin
                    gap_cnt_d = gap_inc_s;
                end
            end else begin
                state_d = state_q;
            end
        end
        burst_active_d = (state_d != ST_HUNT);
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge rx_core_clk or negedge rx_core_reset_n) begin
        if (!rx_core_reset_n) begin
            state_q        <= ST_HUNT;
            prev_q         <= 32'd0;
            bit_offset_q   <= 5'd0;
            len_q          <= 16'd0;
            word_cnt_q     <= 16'd0;
            gap_cnt_q      <= 16'd0;
            m_data_q       <= 32'd0;
            m_valid_q      <= 1'b0;
            m_last_q       <= 1'b0;
            m_onu_id_q     <= 16'd0;
            burst_active_q <= 1'b0;
            err_hdr_q      <= 1'b0;
            err_trunc_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            prev_q         <= prev_d;
            bit_offset_q   <= bit_offset_d;
            len_q          <= len_d;
            word_cnt_q     <= word_cnt_d;
            gap_cnt_q      <= gap_cnt_d;
            m_data_q       <= m_data_d;
            m_valid_q      <= m_valid_d;
            m_last_q       <= m_last_d;
            m_onu_id_q     <= m_onu_id_d;
            burst_active_q <= burst_active_d;
            err_hdr_q      <= err_hdr_d;
            err_trunc_q    <= err_trunc_d;
        end
    end

    assign m_data       = m_data_q;
    assign m_valid      = m_valid_q;
    assign m_last       = m_last_q;
    assign m_onu_id     = m_onu_id_q;
    assign burst_active = burst_active_q;
    assign bit_offset   = bit_offset_q;
    assign err_hdr      = err_hdr_q;
    assign err_trunc    = err_trunc_q;

`ifdef XGPON_RX_STATS_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : (v + 16'd1);
    endfunction

    logic [15:0] ok_cnt_q, ok_cnt_d;
    logic [15:0] hdr_cnt_q, hdr_cnt_d;
    logic [15:0] trc_cnt_q, trc_cnt_d;

    // Statistics next-state: events are taken from the same terms that drive the pulses.
    always_comb begin
        ok_cnt_d  = m_last_d    ? sat_inc16(ok_cnt_q)  : ok_cnt_q;
        hdr_cnt_d = err_hdr_d   ? sat_inc16(hdr_cnt_q) : hdr_cnt_q;
        trc_cnt_d = err_trunc_d ? sat_inc16(trc_cnt_q) : trc_cnt_q;
    end

    // Saturating statistics counters, cleared only by reset.
    always_ff @(posedge rx_core_clk or negedge rx_core_reset_n) begin
        if (!rx_core_reset_n) begin
            ok_cnt_q  <= 16'd0;
            hdr_cnt_q <= 16'd0;
            trc_cnt_q <= 16'd0;
        end else begin
            ok_cnt_q  <= ok_cnt_d;
            hdr_cnt_q <= hdr_cnt_d;
            trc_cnt_q <= trc_cnt_d;
        end
    end

    assign burst_ok_cnt = ok_cnt_q;
    assign hdr_err_cnt  = hdr_cnt_q;
    assign trunc_cnt    = trc_cnt_q;
`else
    assign burst_ok_cnt = 16'd0;
    assign hdr_err_cnt  = 16'd0;
    assign trunc_cnt    = 16'd0;
`endif

endmodule

// File: tb/tb_xgpon_burst_rx_delineator.sv
// Directed self-checking bench for xgpon_burst_rx_delineator (counter expectations follow XGPON_RX_STATS_EN).
module tb_xgpon_burst_rx_delineator;

    localparam logic [31:0] DELIM = 32'hB2C5_0FA1;
`ifdef XGPON_RX_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    logic        rx_core_clk = 1'b0;
    logic        rx_core_reset_n = 1'b0;
    logic [31:0] rx_data = 32'd0;
    logic        rx_data_valid = 1'b0;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_last;
    logic [15:0] m_onu_id;
    logic        burst_active;
    logic [4:0]  bit_offset;
    logic        err_hdr;
    logic        err_trunc;
    logic [15:0] burst_ok_cnt;
    logic [15:0] hdr_err_cnt;
    logic [15:0] trunc_cnt;

    int checks = 0;
    int errors = 0;

    logic [31:0] cap_data[$];
    logic        cap_last[$];
    logic [15:0] cap_onu[$];
    int          hdr_pulses = 0;
    int          trunc_pulses = 0;
    int          active_cycles = 0;

    xgpon_burst_rx_delineator dut (
        .rx_core_clk     (rx_core_clk),
        .rx_core_reset_n (rx_core_reset_n),
        .rx_data         (rx_data),
        .rx_data_valid   (rx_data_valid),
        .m_data          (m_data),
        .m_valid         (m_valid),
        .m_last          (m_last),
        .m_onu_id        (m_onu_id),
        .burst_active    (burst_active),
        .bit_offset      (bit_offset),
        .err_hdr         (err_hdr),
        .err_trunc       (err_trunc),
        .burst_ok_cnt    (burst_ok_cnt),
        .hdr_err_cnt     (hdr_err_cnt),
        .trunc_cnt       (trunc_cnt)
    );

    always #5 rx_core_clk = ~rx_core_clk;

    // Output monitor on the falling edge, away from the active edge.
    always @(negedge rx_core_clk) begin
        if (m_valid) begin
            cap_data.push_back(m_data);
            cap_last.push_back(m_last);
            cap_onu.push_back(m_onu_id);
        end
        if (err_hdr) hdr_pulses++;
        if (err_trunc) trunc_pulses++;
        if (burst_active) active_cycles++;
    end

    task automatic clear_capture();
        cap_data.delete();
        cap_last.delete();
        cap_onu.delete();
        hdr_pulses = 0;
        trunc_pulses = 0;
        active_cycles = 0;
    endtask

    task automatic apply_reset();
        rx_core_reset_n = 1'b0;
        rx_data = 32'd0;
        rx_data_valid = 1'b0;
        repeat (2) @(posedge rx_core_clk);
        #1;
        rx_core_reset_n = 1'b1;
        clear_capture();
    endtask

    task automatic beat(input logic [31:0] d);
        rx_data = d;
        rx_data_valid = 1'b1;
        @(posedge rx_core_clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx_data = 32'd0;
        rx_data_valid = 1'b0;
        repeat (n) @(posedge rx_core_clk);
        #1;
    endtask

    task automatic test_reset();
        rx_core_reset_n = 1'b0;
        @(posedge rx_core_clk);
        #1;
        checks++;
        if ({m_data, m_onu_id, bit_offset} !== 53'd0) begin
            errors++;
            $display("FAIL reset_data: got %h/%h/%0d expected 0/0/0", m_data, m_onu_id, bit_offset);
        end
        checks++;
        if ({m_valid, m_last, burst_active, err_hdr, err_trunc} !== 5'd0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 00000", {m_valid, m_last, burst_active, err_hdr, err_trunc});
        end
        checks++;
        if ({burst_ok_cnt, hdr_err_cnt, trunc_cnt} !== 48'd0) begin
            errors++;
            $display("FAIL reset_cnt: got %h/%h/%h expected 0/0/0", burst_ok_cnt, hdr_err_cnt, trunc_cnt);
        end
        apply_reset();
    endtask

    task automatic test_aligned();
        apply_reset();
        beat(DELIM);
        beat(32'h0004_0012);
        for (int i = 1; i <= 4; i++) beat(32'(i));
        beat(32'd0);
        idle(3);
        checks++;
        if (cap_data.size() !== 4) begin
            errors++;
            $display("FAIL aligned_count: got %0d expected 4", cap_data.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (cap_data[i] !== 32'(i + 1) || cap_last[i] !== (i == 3) || cap_onu[i] !== 16'h0012) begin
                    errors++;
                    $display("FAIL aligned_beat%0d: got %h last=%b onu=%h expected %h last=%b onu=0012",
                             i, cap_data[i], cap_last[i], cap_onu[i], 32'(i + 1), (i == 3));
                end
            end
        end
        checks++;
        if (bit_offset !== 5'd0 || burst_active !== 1'b0) begin
            errors++;
            $display("FAIL aligned_state: got off=%0d active=%b expected off=0 active=0", bit_offset, burst_active);
        end
    endtask

    task automatic test_offset13();
        logic [255:0] stream;
        apply_reset();
        stream = {13'b1_0110_1001_1101, DELIM, 32'h0004_0012, 32'd1, 32'd2, 32'd3, 32'd4, 51'd0};
        for (int i = 0; i < 8; i++) beat(stream[255 - 32 * i -: 32]);
        idle(3);
        checks++;
        if (bit_offset !== 5'd13) begin
            errors++;
            $display("FAIL off13_offset: got %0d expected 13", bit_offset);
        end
        checks++;
        if (cap_data.size() !== 4) begin
            errors++;
            $display("FAIL off13_count: got %0d expected 4", cap_data.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (cap_data[i] !== 32'(i + 1) || cap_last[i] !== (i == 3) || cap_onu[i] !== 16'h0012) begin
                    errors++;
                    $display("FAIL off13_beat%0d: got %h last=%b onu=%h expected %h last=%b onu=0012",
                             i, cap_data[i], cap_last[i], cap_onu[i], 32'(i + 1), (i == 3));
                end
            end
        end
        checks++;
        if (burst_ok_cnt !== 16'(STATS)) begin
            errors++;
            $display("FAIL off13_okcnt: got %0d expected %0d", burst_ok_cnt, STATS);
        end
    endtask

    task automatic test_delim_errors();
        apply_reset();
        beat(DELIM ^ 32'h0000_0007);
        beat(32'h0004_0012);
        for (int i = 1; i <= 4; i++) beat(32'(i));
        beat(32'd0);
        idle(3);
        checks++;
        if (cap_data.size() !== 0 || active_cycles !== 0) begin
            errors++;
            $display("FAIL delim3_nolock: got beats=%0d active=%0d expected 0/0", cap_data.size(), active_cycles);
        end
        clear_capture();
        beat(DELIM ^ 32'h8000_0001);
        beat(32'h0004_0012);
        for (int i = 1; i <= 4; i++) beat(32'(i));
        beat(32'd0);
        idle(3);
        checks++;
        if (cap_data.size() !== 4) begin
            errors++;
            $display("FAIL delim2_count: got %0d expected 4", cap_data.size());
        end else begin
            checks++;
            if (cap_data[0] !== 32'd1 || cap_data[3] !== 32'd4 || cap_last[3] !== 1'b1 || cap_last[2] !== 1'b0) begin
                errors++;
                $display("FAIL delim2_data: got %h..%h last=%b%b expected 1..4 last=01",
                         cap_data[0], cap_data[3], cap_last[2], cap_last[3]);
            end
        end
    endtask

    task automatic test_hdr_errors();
        apply_reset();
        beat(DELIM); beat(32'h0000_0055); beat(32'd0);
        beat(DELIM); beat(32'h0801_0033); beat(32'd0);
        idle(2);
        checks++;
        if (hdr_pulses !== 2 || cap_data.size() !== 0) begin
            errors++;
            $display("FAIL hdr_err_pulses: got pulses=%0d beats=%0d expected 2/0", hdr_pulses, cap_data.size());
        end
        checks++;
        if (hdr_err_cnt !== 16'(2 * STATS)) begin
            errors++;
            $display("FAIL hdr_err_cnt: got %0d expected %0d", hdr_err_cnt, 2 * STATS);
        end
        beat(DELIM); beat(32'h0002_0077); beat(32'hDEAD_BEEF); beat(32'hCAFE_F00D); beat(32'd0);
        idle(2);
        checks++;
        if (cap_data.size() !== 2) begin
            errors++;
            $display("FAIL hdr_legal_count: got %0d expected 2", cap_data.size());
        end else begin
            checks++;
            if (cap_data[0] !== 32'hDEAD_BEEF || cap_data[1] !== 32'hCAFE_F00D || cap_last[0] !== 1'b0 ||
                cap_last[1] !== 1'b1 || cap_onu[1] !== 16'h0077) begin
                errors++;
                $display("FAIL hdr_legal_data: got %h %h last=%b%b onu=%h expected deadbeef cafef00d last=01 onu=0077",
                         cap_data[0], cap_data[1], cap_last[0], cap_last[1], cap_onu[1]);
            end
        end
    endtask

    task automatic test_gap();
        apply_reset();
        beat(DELIM); beat(32'h0004_0042); beat(32'd10); beat(32'd20);
        idle(16);
        beat(32'd30); beat(32'd40); beat(32'd0);
        idle(3);
        checks++;
        if (trunc_pulses !== 1 || cap_data.size() !== 1) begin
            errors++;
            $display("FAIL gap16_abort: got pulses=%0d beats=%0d expected 1/1", trunc_pulses, cap_data.size());
        end else begin
            checks++;
            if (cap_data[0] !== 32'd10 || cap_last[0] !== 1'b0) begin
                errors++;
                $display("FAIL gap16_beat: got %h last=%b expected 0000000a last=0", cap_data[0], cap_last[0]);
            end
        end
        checks++;
        if (trunc_cnt !== 16'(STATS)) begin
            errors++;
            $display("FAIL gap16_cnt: got %0d expected %0d", trunc_cnt, STATS);
        end
        clear_capture();
        beat(DELIM); beat(32'h0004_0042); beat(32'd10); beat(32'd20);
        idle(15);
        beat(32'd30); beat(32'd40); beat(32'd0);
        idle(3);
        checks++;
        if (trunc_pulses !== 0 || cap_data.size() !== 4) begin
            errors++;
            $display("FAIL gap15_complete: got pulses=%0d beats=%0d expected 0/4", trunc_pulses, cap_data.size());
        end else begin
            checks++;
            if (cap_data[2] !== 32'd30 || cap_data[3] !== 32'd40 || cap_last[3] !== 1'b1 || cap_onu[3] !== 16'h0042) begin
                errors++;
                $display("FAIL gap15_data: got %h %h last=%b onu=%h expected 1e 28 last=1 onu=0042",
                         cap_data[2], cap_data[3], cap_last[3], cap_onu[3]);
            end
        end
        checks++;
        if (burst_ok_cnt !== 16'(STATS) || trunc_cnt !== 16'(STATS)) begin
            errors++;
            $display("FAIL gap15_cnt: got ok=%0d trunc=%0d expected %0d/%0d", burst_ok_cnt, trunc_cnt, STATS, STATS);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_d [5];
        logic        exp_l [5];
        logic [15:0] exp_o [5];
        exp_d = '{32'd1, 32'd2, 32'd5, 32'd6, 32'd7};
        exp_l = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        exp_o = '{16'h00A1, 16'h00A1, 16'h00B2, 16'h00B2, 16'h00B2};
        apply_reset();
        beat(DELIM); beat(32'h0002_00A1); beat(32'd1); beat(32'd2);
        beat(DELIM); beat(32'h0003_00B2); beat(32'd5); beat(32'd6); beat(32'd7);
        beat(DELIM); beat(32'h0004_00C3); beat(32'd9); beat(32'd10);
        checks++;
        if (cap_data.size() !== 5) begin
            errors++;
            $display("FAIL b2b_count: got %0d expected 5", cap_data.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (cap_data[i] !== exp_d[i] || cap_last[i] !== exp_l[i] || cap_onu[i] !== exp_o[i]) begin
                    errors++;
                    $display("FAIL b2b_beat%0d: got %h last=%b onu=%h expected %h last=%b onu=%h",
                             i, cap_data[i], cap_last[i], cap_onu[i], exp_d[i], exp_l[i], exp_o[i]);
                end
            end
        end
        checks++;
        if (m_valid !== 1'b1 || m_data !== 32'd9 || m_onu_id !== 16'h00C3 || burst_ok_cnt !== 16'(2 * STATS)) begin
            errors++;
            $display("FAIL b2b_third: got v=%b d=%h onu=%h ok=%0d expected v=1 d=9 onu=00c3 ok=%0d",
                     m_valid, m_data, m_onu_id, burst_ok_cnt, 2 * STATS);
        end
        #1;
        rx_core_reset_n = 1'b0;
        #1;
        checks++;
        if ({m_valid, m_last, burst_active, m_data, m_onu_id, bit_offset} !== 56'd0 ||
            {burst_ok_cnt, hdr_err_cnt, trunc_cnt} !== 48'd0) begin
            errors++;
            $display("FAIL midburst_reset: got v=%b l=%b act=%b d=%h onu=%h ok=%0d expected all 0",
                     m_valid, m_last, burst_active, m_data, m_onu_id, burst_ok_cnt);
        end
        repeat (2) @(posedge rx_core_clk);
        #1;
        rx_core_reset_n = 1'b1;
        beat(32'd10);
        idle(2);
        checks++;
        if (burst_active !== 1'b0 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_hunt: got act=%b v=%b expected 0/0", burst_active, m_valid);
        end
    endtask

    initial begin
        test_reset();
        test_aligned();
        test_offset13();
        test_delim_errors();
        test_hdr_errors();
        test_gap();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
